// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA engine.
//   - subop encodings for LOAD / STORE
//   - FSM state enum used by dma_engine
//   - bit positions of the fields in the 128-bit command word
//   - burst sizing helper used by dma_addr_gen
package dma_pkg;

    localparam logic [7:0] DMA_LOAD  = 8'h01;
    localparam logic [7:0] DMA_STORE = 8'h02;

    // Command word field positions (msb/lsb inclusive)
    localparam int unsigned CmdOpMsb    = 127;
    localparam int unsigned CmdOpLsb    = 120;
    localparam int unsigned CmdSubopMsb = 119;
    localparam int unsigned CmdSubopLsb = 112;
    localparam int unsigned CmdExtMsb   = 111;
    localparam int unsigned CmdExtLsb   = 72;
    localparam int unsigned CmdIntMsb   = 71;
    localparam int unsigned CmdIntLsb   = 52;
    localparam int unsigned CmdRowsMsb  = 51;
    localparam int unsigned CmdRowsLsb  = 40;
    localparam int unsigned CmdColsMsb  = 39;
    localparam int unsigned CmdColsLsb  = 28;
    localparam int unsigned CmdSsMsb    = 27;
    localparam int unsigned CmdSsLsb    = 16;
    localparam int unsigned CmdDsMsb    = 15;
    localparam int unsigned CmdDsLsb    = 4;

    localparam int unsigned MaxBurst = 256;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StLdAr = 4'd1,
        StLdR  = 4'd2,
        StStAw = 4'd3,
        StStRd = 4'd4,
        StStW  = 4'd5,
        StStB  = 4'd6,
        StNext = 4'd7,
        StDone = 4'd8
    } dma_state_e;

    // Beats in the next burst given the beats still left in the row.
    function automatic logic [8:0] burst_beats(input logic [11:0] remaining);
        return (remaining > 12'(MaxBurst)) ? 9'(MaxBurst) : remaining[8:0];
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: row/beat counters, burst split and address generation.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             latch a new command (bases, strides, geometry)
//   is_load_i           LOAD: external is the source; STORE: SRAM is the source
//   ext_base_i/int_base_i, rows_i, cols_i, src_stride_i, dst_stride_i  command fields
//   burst_start_i       address handshake of a burst done: load burst beat counter
//   beat_i              one data beat transferred
//   next_i              burst finished: step to next row if the row is complete
//   ext_addr_o/int_addr_o  current external / SRAM byte addresses
//   burst_len_o         AXI len of the burst starting at the current column
//   burst_last_o        current beat is the last of its burst
//   all_done_o          last row fully transferred
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int unsigned Bytes = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic [39:0] ext_base_i,
    input  logic [19:0] int_base_i,
    input  logic [11:0] rows_i,
    input  logic [11:0] cols_i,
    input  logic [11:0] src_stride_i,
    input  logic [11:0] dst_stride_i,
    input  logic        burst_start_i,
    input  logic        beat_i,
    input  logic        next_i,
    output logic [39:0] ext_addr_o,
    output logic [19:0] int_addr_o,
    output logic [7:0]  burst_len_o,
    output logic        burst_last_o,
    output logic        all_done_o
);

    localparam logic [39:0] ExtStep = 40'(Bytes);
    localparam logic [19:0] IntStep = 20'(Bytes);

    logic [39:0] ext_row_q, ext_row_d, ext_q, ext_d;
    logic [19:0] int_row_q, int_row_d, int_q, int_d;
    logic [11:0] ext_stride_q, ext_stride_d, int_stride_q, int_stride_d;
    logic [11:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
    logic [8:0]  burst_left_q, burst_left_d;
    logic        row_end;

    assign row_end      = (col_q == cols_q);
    assign all_done_o   = row_end && (row_q == rows_q - 12'd1);
    assign burst_len_o  = 8'(burst_beats(cols_q - col_q) - 9'd1);
    assign burst_last_o = (burst_left_q == 9'd1);
    assign ext_addr_o   = ext_q;
    assign int_addr_o   = int_q;

    always_comb begin
        ext_row_d    = ext_row_q;
        ext_d        = ext_q;
        int_row_d    = int_row_q;
        int_d        = int_q;
        ext_stride_d = ext_stride_q;
        int_stride_d = int_stride_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        row_d        = row_q;
        col_d        = col_q;
        burst_left_d = burst_left_q;
        if (start_i) begin
            ext_row_d    = ext_base_i;
            ext_d        = ext_base_i;
            int_row_d    = int_base_i;
            int_d        = int_base_i;
            ext_stride_d = is_load_i ? src_stride_i : dst_stride_i;
            int_stride_d = is_load_i ? dst_stride_i : src_stride_i;
            rows_d       = rows_i;
            cols_d       = cols_i;
            row_d        = '0;
            col_d        = '0;
            burst_left_d = '0;
        end else if (burst_start_i) begin
            burst_left_d = burst_beats(cols_q - col_q);
        end else if (beat_i) begin
            ext_d        = ext_q + ExtStep;
            int_d        = int_q + IntStep;
            col_d        = col_q + 12'd1;
            burst_left_d = burst_left_q - 9'd1;
        end else if (next_i && row_end) begin
            // Row bases advance by the stride; beat addresses restart at the new base.
            row_d     = row_q + 12'd1;
            col_d     = '0;
            ext_row_d = ext_row_q + {28'd0, ext_stride_q};
            ext_d     = ext_row_d;
            int_row_d = int_row_q + {8'd0, int_stride_q};
            int_d     = int_row_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_row_q    <= '0;
            ext_q        <= '0;
            int_row_q    <= '0;
            int_q        <= '0;
            ext_stride_q <= '0;
            int_stride_q <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            burst_left_q <= '0;
        end else begin
            ext_row_q    <= ext_row_d;
            ext_q        <= ext_d;
            int_row_q    <= int_row_d;
            int_q        <= int_d;
            ext_stride_q <= ext_stride_d;
            int_stride_q <= int_stride_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            row_q        <= row_d;
            col_q        <= col_d;
            burst_left_q <= burst_left_d;
        end
    end

endmodule

// File: rtl/dma_engine.sv
// dma_engine: command-driven 2-D strided DMA between AXI4 memory and on-chip SRAM.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd/cmd_valid/cmd_ready        128-bit command handshake (ready only when idle)
//   cmd_done                       one-cycle completion pulse
//   sram_*                         SRAM port (20-bit byte address, read data one cycle late)
//   axi_ar*/axi_r*                 AXI4 read channels (LOAD)
//   axi_aw*/axi_w*/axi_b*          AXI4 write channels (STORE)
//   cmd_error                      only with DMA_BRESP_CHECK_EN: a non-OKAY bresp was seen
// Build option: define DMA_BRESP_CHECK_EN to add bresp checking and the cmd_error port.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          cmd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  cmd_done,
`ifdef DMA_BRESP_CHECK_EN
    output logic                  cmd_error,
`endif
    output logic [19:0]           sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_we,
    output logic                  sram_re,
    input  logic                  sram_ready,
    output logic [39:0]           axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_wlast,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [39:0]           axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    dma_state_e            state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] hold_q;

    logic [7:0]  subop;
    logic        is_load_cmd, degenerate;
    logic        ag_start, ag_burst_start, ag_beat, ag_next;
    logic [39:0] ag_ext;
    logic [19:0] ag_int;
    logic [7:0]  ag_len;
    logic        ag_burst_last, ag_all_done;

    assign subop       = cmd[CmdSubopMsb:CmdSubopLsb];
    assign is_load_cmd = (subop == DMA_LOAD);
    assign degenerate  = (cmd[CmdRowsMsb:CmdRowsLsb] == 12'd0) ||
                         (cmd[CmdColsMsb:CmdColsLsb] == 12'd0) ||
                         ((subop != DMA_LOAD) && (subop != DMA_STORE));

    dma_addr_gen #(
        .Bytes (DATA_WIDTH / 8)
    ) u_addr_gen (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (ag_start),
        .is_load_i     (is_load_cmd),
        .ext_base_i    (cmd[CmdExtMsb:CmdExtLsb]),
        .int_base_i    (cmd[CmdIntMsb:CmdIntLsb]),
        .rows_i        (cmd[CmdRowsMsb:CmdRowsLsb]),
        .cols_i        (cmd[CmdColsMsb:CmdColsLsb]),
        .src_stride_i  (cmd[CmdSsMsb:CmdSsLsb]),
        .dst_stride_i  (cmd[CmdDsMsb:CmdDsLsb]),
        .burst_start_i (ag_burst_start),
        .beat_i        (ag_beat),
        .next_i        (ag_next),
        .ext_addr_o    (ag_ext),
        .int_addr_o    (ag_int),
        .burst_len_o   (ag_len),
        .burst_last_o  (ag_burst_last),
        .all_done_o    (ag_all_done)
    );

    assign axi_araddr = ag_ext;
    assign axi_awaddr = ag_ext;
    assign axi_arlen  = ag_len;
    assign axi_awlen  = ag_len;
    assign sram_addr  = ag_int;
    assign axi_wdata  = hold_q;

    always_comb begin
        state_d        = state_q;
        is_load_d      = is_load_q;
        rd_pend_d      = 1'b0;
        cmd_ready      = 1'b0;
        cmd_done       = 1'b0;
        sram_we        = 1'b0;
        sram_re        = 1'b0;
        sram_wdata     = '0;
        axi_arvalid    = 1'b0;
        axi_rready     = 1'b0;
        axi_awvalid    = 1'b0;
        axi_wvalid     = 1'b0;
        axi_wlast      = 1'b0;
        axi_bready     = 1'b0;
        ag_start       = 1'b0;
        ag_burst_start = 1'b0;
        ag_beat        = 1'b0;
        ag_next        = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ag_start  = 1'b1;
                    is_load_d = is_load_cmd;
                    if (degenerate)       state_d = StDone;
                    else if (is_load_cmd) state_d = StLdAr;
                    else                  state_d = StStAw;
                end
            end
            StLdAr: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    ag_burst_start = 1'b1;
                    state_d        = StLdR;
                end
            end
            StLdR: begin
                // Only take a beat when the SRAM can absorb it in the same cycle.
                axi_rready = sram_ready;
                if (axi_rvalid && sram_ready) begin
                    sram_we    = 1'b1;
                    sram_wdata = axi_rdata;
                    ag_beat    = 1'b1;
                    if (axi_rlast || ag_burst_last) state_d = StNext;
                end
            end
            StStAw: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    ag_burst_start = 1'b1;
                    state_d        = StStRd;
                end
            end
            StStRd: begin
                sram_re = 1'b1;
                if (sram_ready) begin
                    rd_pend_d = 1'b1;
                    state_d   = StStW;
                end
            end
            StStW: begin
                // First cycle here waits for the read data to land in hold_q.
                if (!rd_pend_q) begin
                    axi_wvalid = 1'b1;
                    axi_wlast  = ag_burst_last;
                    if (axi_wready) begin
                        ag_beat = 1'b1;
                        state_d = ag_burst_last ? StStB : StStRd;
                    end
                end
            end
            StStB: begin
                axi_bready = 1'b1;
                if (axi_bvalid) state_d = StNext;
            end
            StNext: begin
                ag_next = 1'b1;
                if (ag_all_done) state_d = StDone;
                else             state_d = is_load_q ? StLdAr : StStAw;
            end
            StDone: begin
                cmd_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_load_q <= 1'b0;
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            rd_pend_q <= rd_pend_d;
            if (rd_pend_q) hold_q <= sram_rdata;
        end
    end

`ifdef DMA_BRESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ag_start) err_d = 1'b0;
        else if (axi_bvalid && axi_bready && (axi_bresp != 2'b00)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign cmd_error = (state_q == StDone) && err_q;

    logic unused_bits;
    assign unused_bits = ^{cmd[CmdOpMsb:CmdOpLsb], cmd[3:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{cmd[CmdOpMsb:CmdOpLsb], cmd[3:0], axi_bresp};
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Testbench for dma_engine: AXI/SRAM responders, reference model of the
// expected address/data traffic, directed and randomized commands.
module tb_dma_engine;

    localparam int unsigned DW     = 256;
    localparam int unsigned BY     = DW / 8;
    localparam int          Budget = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  cmd;
    logic          cmd_valid;
    logic          cmd_ready, cmd_done;
`ifdef DMA_BRESP_CHECK_EN
    logic          cmd_error;
`endif
    logic [19:0]   sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_we, sram_re, sram_ready;
    logic [39:0]   axi_awaddr, axi_araddr;
    logic [7:0]    axi_awlen, axi_arlen;
    logic          axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic          axi_rlast, axi_rvalid, axi_rready;

    always #5 clk = ~clk;

    dma_engine #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
`ifdef DMA_BRESP_CHECK_EN
        .cmd_error   (cmd_error),
`endif
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_we     (sram_we),
        .sram_re     (sram_re),
        .sram_ready  (sram_ready),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    // Observed traffic
    logic [47:0]  ar_log[$], aw_log[$];
    logic [275:0] wr_log[$];
    logic [19:0]  rd_log[$];
    logic [256:0] w_log[$];
    // Expected traffic
    logic [47:0]  exp_ar[$], exp_aw[$];
    logic [275:0] exp_wr[$];
    logic [19:0]  exp_rd[$];
    logic [256:0] exp_w[$];
    // Responder state
    logic [40:0]  r_q[$];
    int           b_pend;

    function automatic logic [DW-1:0] ext_pat(input logic [39:0] a);
        return {(DW/32){32'hAA00_0000 ^ a[31:0]}};
    endfunction

    function automatic logic [DW-1:0] sram_pat(input logic [19:0] a);
        return {(DW/32){32'h5500_0000 ^ {12'h0, a}}};
    endfunction

    function automatic logic [39:0] ext_at(input logic [39:0] base, input int r, input int st,
                                           input int b);
        logic [63:0] t;
        t = 64'(base) + 64'(r) * 64'(st) + 64'(b) * 64'(BY);
        return t[39:0];
    endfunction

    function automatic logic [19:0] int_at(input logic [19:0] base, input int r, input int st,
                                           input int b);
        logic [63:0] t;
        t = 64'(base) + 64'(r) * 64'(st) + 64'(b) * 64'(BY);
        return t[19:0];
    endfunction

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the traffic a command must produce.
    task automatic build(input logic [7:0] subop, input logic [39:0] ext, input logic [19:0] ib,
                         input int rows, input int cols, input int ss, input int ds);
        int n;
        exp_ar.delete(); exp_aw.delete(); exp_wr.delete(); exp_rd.delete(); exp_w.delete();
        if (rows == 0 || cols == 0 || (subop != 8'h01 && subop != 8'h02)) return;
        for (int r = 0; r < rows; r++) begin
            for (int c0 = 0; c0 < cols; c0 += 256) begin
                n = (cols - c0 > 256) ? 256 : cols - c0;
                if (subop == 8'h01) begin
                    exp_ar.push_back({ext_at(ext, r, ss, c0), 8'(n - 1)});
                    for (int b = c0; b < c0 + n; b++)
                        exp_wr.push_back({int_at(ib, r, ds, b), ext_pat(ext_at(ext, r, ss, b))});
                end else begin
                    exp_aw.push_back({ext_at(ext, r, ds, c0), 8'(n - 1)});
                    for (int b = c0; b < c0 + n; b++) begin
                        exp_rd.push_back(int_at(ib, r, ss, b));
                        exp_w.push_back({(b == c0 + n - 1), sram_pat(int_at(ib, r, ss, b))});
                    end
                end
            end
        end
    endtask

    // AXI slave + SRAM responder: sample 1ns before the edge, drive 1ns after.
    initial begin
        logic        rd_hit;
        logic [19:0] rd_a;
        logic [40:0] fr;
        rd_a = '0;
        axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
        axi_bvalid = 1'b0; axi_bresp = 2'b00;
        sram_ready = 1'b0; sram_rdata = '0;
        b_pend = 0;
        forever begin
            @(negedge clk);
            #4;
            rd_hit = 1'b0;
            if (rst) begin
                r_q.delete();
                b_pend = 0;
            end else begin
                if (axi_arvalid && axi_arready) begin
                    ar_log.push_back({axi_araddr, axi_arlen});
                    for (int i = 0; i <= int'(axi_arlen); i++)
                        r_q.push_back({(i == int'(axi_arlen)), axi_araddr + 40'(i * BY)});
                end
                if (axi_rvalid && axi_rready) void'(r_q.pop_front());
                if (sram_we && sram_ready) wr_log.push_back({sram_addr, sram_wdata});
                if (sram_re && sram_ready) begin
                    rd_log.push_back(sram_addr);
                    rd_hit = 1'b1;
                    rd_a   = sram_addr;
                end
                if (axi_awvalid && axi_awready) aw_log.push_back({axi_awaddr, axi_awlen});
                if (axi_wvalid && axi_wready) begin
                    w_log.push_back({axi_wlast, axi_wdata});
                    if (axi_wlast) b_pend++;
                end
                if (axi_bvalid && axi_bready) b_pend--;
            end
            @(posedge clk);
            #1;
            axi_arready = 1'b1;
            axi_awready = 1'b1;
            sram_ready  = rand_mode ? 1'($urandom) : 1'b1;
            axi_wready  = rand_mode ? 1'($urandom) : 1'b1;
            axi_bvalid  = (b_pend > 0);
            if (r_q.size() > 0) begin
                fr         = r_q[0];
                axi_rvalid = 1'b1;
                axi_rdata  = ext_pat(fr[39:0]);
                axi_rlast  = fr[40];
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                axi_rdata  = {(DW/32){$urandom}};
            end
            sram_rdata = rd_hit ? sram_pat(rd_a) : {(DW/32){$urandom}};
        end
    end

    task automatic send(input logic [127:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = {4{$urandom}};
    endtask

    task automatic run(input string nm, input logic [7:0] subop, input logic [39:0] ext,
                       input logic [19:0] ib, input int rows, input int cols, input int ss,
                       input int ds, input bit rnd);
        int cyc;
        bit degen;
        degen = (rows == 0 || cols == 0 || (subop != 8'h01 && subop != 8'h02));
        build(subop, ext, ib, rows, cols, ss, ds);
        ar_log.delete(); aw_log.delete(); wr_log.delete(); rd_log.delete(); w_log.delete();
        rand_mode = rnd;
        @(negedge clk);
        chk({nm, " ready_before"}, cmd_ready, 1'b1);
        send({8'h03, subop, ext, ib, 12'(rows), 12'(cols), 12'(ss), 12'(ds), 4'h0});
        cyc = 0;
        while (!cmd_done && cyc < Budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done"}, cmd_done, 1'b1);
        if (degen) chk({nm, " done_latency"}, cyc, 0);
        @(negedge clk);
        chk({nm, " done_pulse"}, cmd_done, 1'b0);
        chk({nm, " ready_after"}, cmd_ready, 1'b1);
        if (cyc >= Budget) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        chk({nm, " ar_count"}, ar_log.size(), exp_ar.size());
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
            chk($sformatf("%s ar[%0d]", nm, i), ar_log[i], exp_ar[i]);
        chk({nm, " aw_count"}, aw_log.size(), exp_aw.size());
        for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++)
            chk($sformatf("%s aw[%0d]", nm, i), aw_log[i], exp_aw[i]);
        chk({nm, " sram_wr_count"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk($sformatf("%s sram_wr[%0d]", nm, i), wr_log[i], exp_wr[i]);
        chk({nm, " sram_rd_count"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk($sformatf("%s sram_rd[%0d]", nm, i), rd_log[i], exp_rd[i]);
        chk({nm, " w_count"}, w_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++)
            chk($sformatf("%s w[%0d]", nm, i), w_log[i], exp_w[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] e;
        logic [19:0] ib;
        logic [7:0]  sop;
        rst       = 1'b1;
        cmd       = '0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        chk("reset cmd_ready", cmd_ready, 1'b1);
        chk("reset state", dut.state_q, 4'd0);
        chk("reset strobes",
            {sram_we, sram_re, axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
             cmd_done}, 8'h00);
        chk("reset addrs", {axi_araddr, axi_awaddr, sram_addr}, 100'h0);

        run("ld_1x1",  8'h01, 40'h0, 20'h0, 1, 1, 32, 32, 1'b0);
        repeat (5) @(negedge clk);
        chk("ld_1x1 state_idle", dut.state_q, 4'd0);
        chk("ld_1x1 ready_idle", cmd_ready, 1'b1);
        run("ld_2x2",  8'h01, 40'h0, 20'h0, 2, 2, 'h100, 'h40, 1'b0);
        run("st_1x3",  8'h02, 40'h1000, 20'h20, 1, 3, 32, 32, 1'b0);
        run("cols0",   8'h01, 40'h40, 20'h40, 1, 0, 32, 32, 1'b0);
        run("rows0",   8'h02, 40'h40, 20'h40, 0, 3, 32, 32, 1'b0);
        run("subop07", 8'h07, 40'h40, 20'h40, 1, 1, 32, 32, 1'b0);
        run("ld_rand4", 8'h01, 40'h8000, 20'h100, 1, 4, 32, 32, 1'b1);
        run("st_rand4", 8'h02, 40'h9000, 20'h200, 1, 4, 32, 32, 1'b1);

        for (int k = 0; k < 6; k++) begin
            e   = {8'($urandom), $urandom};
            ib  = 20'($urandom);
            sop = ($urandom % 2 == 0) ? 8'h01 : 8'h02;
            run($sformatf("rnd%0d", k), sop, e, ib, 1 + int'($urandom % 3),
                1 + int'($urandom % 5), int'($urandom % 4096), int'($urandom % 4096), 1'b1);
        end

        run("ld_split", 8'h01, 40'hFF_FFFF_F000, 20'hFF000, 1, 300, 32, 32, 1'b0);
        run("st_split", 8'h02, 40'h20_0000, 20'h1000, 1, 260, 32, 32, 1'b1);

        // Reset in the middle of a long transfer.
        rand_mode = 1'b1;
        @(negedge clk);
        send({8'h03, 8'h01, 40'h5000, 20'h0, 12'd3, 12'd100, 12'd0, 12'd0, 4'h0});
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst state", dut.state_q, 4'd0);
        chk("midrst ready", cmd_ready, 1'b1);
        chk("midrst strobes",
            {sram_we, sram_re, axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
             cmd_done}, 8'h00);
        run("after_rst", 8'h01, 40'h40, 20'h80, 2, 2, 64, 64, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
